// File: rtl/aes_round_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_ctrl_if
// Description : Start request and stage-control bundle between an AES-128
//               round datapath (master) and its sequencing controller
//               (slave).
//   start        - request to encrypt (master -> slave)
//   load_sel     - select plaintext/cipher key instead of feedback
//   add_round_en - AddRoundKey register enable
//   sub_en       - SubBytes stage enable
//   shift_en     - ShiftRows stage enable
//   mix_en       - MixColumns stage enable
//   key_exp_en   - key-expansion register enable
//   rcon[7:0]    - round constant for the current round
//   round[3:0]   - current round number
//   result_en    - ciphertext valid strobe
//   busy         - controller is running a block
//   done         - same as result_en
// Revision    : 1.0 - initial release
// ============================================================================
interface aes_round_ctrl_if;
  logic       start;
  logic       load_sel;
  logic       add_round_en;
  logic       sub_en;
  logic       shift_en;
  logic       mix_en;
  logic       key_exp_en;
  logic [7:0] rcon;
  logic [3:0] round;
  logic       result_en;
  logic       busy;
  logic       done;

  modport master (
    output start,
    input  load_sel, add_round_en, sub_en, shift_en, mix_en, key_exp_en,
    input  rcon, round, result_en, busy, done
  );

  modport slave (
    input  start,
    output load_sel, add_round_en, sub_en, shift_en, mix_en, key_exp_en,
    output rcon, round, result_en, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aes_round_ctrl
// Description : Sequencing controller for an AES-128 encryption datapath.
//               Steps INIT, then per round SUB/SHIFT/MIX/ARK (the last round
//               skips MIX), then a one-cycle DONE strobe. Moore machine:
//               every output decodes from the registered state and round.
// Ports       :
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset
//   bus   - aes_round_ctrl_if.slave (start in, stage controls out)
// Parameters  :
//   NR    - number of rounds, 1..10
// Revision    : 1.0 - initial release
// ============================================================================
module aes_round_ctrl #(
  parameter int unsigned NR = 10
) (
  input  logic             clk,
  input  logic             reset,
  aes_round_ctrl_if.slave  bus
);

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_init  = 3'd1;
  localparam logic [2:0] c_st_sub   = 3'd2;
  localparam logic [2:0] c_st_shift = 3'd3;
  localparam logic [2:0] c_st_mix   = 3'd4;
  localparam logic [2:0] c_st_ark   = 3'd5;
  localparam logic [2:0] c_st_done  = 3'd6;

  localparam logic [3:0] c_nr = 4'(NR);

  logic [2:0] state_q, state_d;
  logic [3:0] round_q, round_d;

  // Next-state and round-counter logic.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    case (state_q)
      c_st_idle: begin
        if (bus.start) begin
          state_d = c_st_init;
          round_d = 4'd0;
        end
      end
      c_st_init: begin
        state_d = c_st_sub;
        round_d = 4'd1;
      end
      c_st_sub: state_d = c_st_shift;
      // The final round has no MixColumns.
      c_st_shift: state_d = (round_q < c_nr) ? c_st_mix : c_st_ark;
      c_st_mix:   state_d = c_st_ark;
      c_st_ark: begin
        if (round_q < c_nr) begin
          state_d = c_st_sub;
          round_d = round_q + 4'd1;
        end else begin
          state_d = c_st_done;
        end
      end
      c_st_done: begin
        state_d = c_st_idle;
        round_d = 4'd0;
      end
      default: begin
        // Unused encoding: recover to IDLE.
        state_d = c_st_idle;
        round_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= c_st_idle;
      round_q <= 4'd0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
    end
  end

  // Output decode from registered state only.
  logic       load_sel_w;
  logic       add_round_en_w;
  logic       sub_en_w;
  logic       shift_en_w;
  logic       mix_en_w;
  logic       result_en_w;
  logic       busy_w;
  logic [7:0] rcon_w;

  always_comb begin
    load_sel_w     = 1'b0;
    add_round_en_w = 1'b0;
    sub_en_w       = 1'b0;
    shift_en_w     = 1'b0;
    mix_en_w       = 1'b0;
    result_en_w    = 1'b0;
    busy_w         = 1'b1;
    case (state_q)
      c_st_init: begin
        load_sel_w     = 1'b1;
        add_round_en_w = 1'b1;
      end
      c_st_sub:   sub_en_w       = 1'b1;
      c_st_shift: shift_en_w     = 1'b1;
      c_st_mix:   mix_en_w       = 1'b1;
      c_st_ark:   add_round_en_w = 1'b1;
      c_st_done:  result_en_w    = 1'b1;
      default:    busy_w         = 1'b0;
    endcase
  end

  // Round constants for rounds 1..10; anything else yields zero.
  always_comb begin
    case (round_q)
      4'd1:    rcon_w = 8'h01;
      4'd2:    rcon_w = 8'h02;
      4'd3:    rcon_w = 8'h04;
      4'd4:    rcon_w = 8'h08;
      4'd5:    rcon_w = 8'h10;
      4'd6:    rcon_w = 8'h20;
      4'd7:    rcon_w = 8'h40;
      4'd8:    rcon_w = 8'h80;
      4'd9:    rcon_w = 8'h1B;
      4'd10:   rcon_w = 8'h36;
      default: rcon_w = 8'h00;
    endcase
  end

  assign bus.load_sel     = load_sel_w;
  assign bus.add_round_en = add_round_en_w;
  assign bus.sub_en       = sub_en_w;
  assign bus.shift_en     = shift_en_w;
  assign bus.mix_en       = mix_en_w;
  // The next round key is registered alongside SubBytes.
  assign bus.key_exp_en   = sub_en_w;
  assign bus.rcon         = rcon_w;
  assign bus.round        = round_q;
  assign bus.result_en    = result_en_w;
  assign bus.busy         = busy_w;
  assign bus.done         = result_en_w;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_round_ctrl
// Description : Self-checking bench for aes_round_ctrl. Two instances
//               (NR=10 and NR=1) share start/reset and are compared each
//               cycle against a cycle-index schedule model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start_v = 1'b0;

  always #5 clk = ~clk;

  aes_round_ctrl_if if10();
  aes_round_ctrl_if if1();

  assign if10.start = start_v;
  assign if1.start  = start_v;

  aes_round_ctrl #(.NR(10)) dut10 (.clk(clk), .reset(reset), .bus(if10.slave));
  aes_round_ctrl #(.NR(1))  dut1  (.clk(clk), .reset(reset), .bus(if1.slave));

  logic [20:0] obs10, obs1;
  assign obs10 = {if10.load_sel, if10.add_round_en, if10.sub_en, if10.shift_en,
                  if10.mix_en, if10.key_exp_en, if10.rcon, if10.round,
                  if10.result_en, if10.busy, if10.done};
  assign obs1  = {if1.load_sel, if1.add_round_en, if1.sub_en, if1.shift_en,
                  if1.mix_en, if1.key_exp_en, if1.rcon, if1.round,
                  if1.result_en, if1.busy, if1.done};

  int checks = 0;
  int errors = 0;

  // Model: position in the run, 0 = idle, 1..4*NR+1 = cycle after start.
  int c10 = 0;
  int c1  = 0;

  // Per-run tallies for the NR=10 instance.
  bit counting = 0;
  int cyc_n, ark_n, sub_n, shift_n, mix_n, key_n, busy_n, done_n, done_at;

  // AES round constant: repeated doubling in GF(2^8).
  function automatic logic [7:0] rcon_ref(int r);
    logic [7:0] x;
    if (r == 0) return 8'h00;
    x = 8'h01;
    for (int i = 1; i < r; i++)
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    return x;
  endfunction

  function automatic logic [20:0] exp_vec(int c, int nr);
    logic ld, ark, sb, sh, mx, res, bsy;
    int r, ph;
    ld = 0; ark = 0; sb = 0; sh = 0; mx = 0; res = 0; bsy = 0; r = 0;
    if (c == 1) begin
      ld = 1; ark = 1; bsy = 1;
    end else if (c == 4 * nr + 1) begin
      res = 1; bsy = 1; r = nr;
    end else if (c >= 2) begin
      bsy = 1;
      r  = (c + 2) / 4;
      ph = (c + 2) % 4;
      if (ph == 0) sb = 1;
      else if (ph == 1) sh = 1;
      else if (ph == 2 && r < nr) mx = 1;
      else ark = 1;
    end
    return {ld, ark, sb, sh, mx, sb, rcon_ref(r), 4'(r), res, bsy, res};
  endfunction

  function automatic int adv(int c, int nr, logic st);
    if (c == 0) return st ? 1 : 0;
    if (c == 4 * nr + 1) return 0;
    return c + 1;
  endfunction

  task automatic chk(string tag, logic [20:0] obs, logic [20:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(string tag, int obs, int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      c10 = 0; c1 = 0;
    end else begin
      c10 = adv(c10, 10, start_v);
      c1  = adv(c1, 1, start_v);
    end
    @(negedge clk);
    chk("cycle_nr10", obs10, exp_vec(c10, 10));
    chk("cycle_nr1", obs1, exp_vec(c1, 1));
    if (counting) begin
      cyc_n++;
      ark_n   += int'(if10.add_round_en);
      sub_n   += int'(if10.sub_en);
      shift_n += int'(if10.shift_en);
      mix_n   += int'(if10.mix_en);
      key_n   += int'(if10.key_exp_en);
      busy_n  += int'(if10.busy);
      if (if10.done) begin
        done_n++;
        done_at = cyc_n;
      end
    end
  endtask

  // Assert reset between edges and check outputs before the next edge.
  task automatic async_rst(string tag);
    #2 reset = 1'b1;
    #1 c10 = 0; c1 = 0;
    chk(tag, obs10, exp_vec(0, 10));
    chk(tag, obs1, exp_vec(0, 1));
  endtask

  initial begin
    // Power-up reset with start high.
    start_v = 1'b1;
    #1 reset = 1'b1;
    #2;
    chk("reset_nr10", obs10, exp_vec(0, 10));
    chk("reset_nr1", obs1, exp_vec(0, 1));
    repeat (3) tick();
    reset = 1'b0;
    start_v = 1'b0;
    repeat (2) tick();

    // Single run with a one-cycle start pulse.
    cyc_n = 0; ark_n = 0; sub_n = 0; shift_n = 0; mix_n = 0;
    key_n = 0; busy_n = 0; done_n = 0; done_at = 0;
    counting = 1;
    start_v = 1'b1;
    tick();
    start_v = 1'b0;
    repeat (45) tick();
    counting = 0;
    chk_int("count_ark", ark_n, 11);
    chk_int("count_sub", sub_n, 10);
    chk_int("count_shift", shift_n, 10);
    chk_int("count_mix", mix_n, 9);
    chk_int("count_key", key_n, 10);
    chk_int("count_busy", busy_n, 41);
    chk_int("count_done", done_n, 1);
    chk_int("done_cycle", done_at, 41);

    // Start held high: back-to-back runs with a single IDLE gap.
    start_v = 1'b1;
    repeat (130) tick();
    start_v = 1'b0;
    repeat (3) tick();

    // Reset during round 5 MixColumns.
    start_v = 1'b1;
    tick();
    start_v = 1'b0;
    for (int n = 0; n < 50 && c10 != 20; n++) tick();
    chk_int("reach_r5_mix", c10, 20);
    async_rst("reset_mid_run");
    repeat (2) tick();
    reset = 1'b0;
    tick();
    start_v = 1'b1;
    tick();
    start_v = 1'b0;
    repeat (45) tick();

    // Random start traffic with occasional asynchronous resets.
    for (int n = 0; n < 800; n++) begin
      start_v = ($urandom_range(0, 2) == 0);
      tick();
      if ($urandom_range(0, 149) == 0) begin
        async_rst("reset_random");
        tick();
        reset = 1'b0;
      end
    end
    start_v = 1'b0;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
